// File: rtl/board_row_if.sv
// board_row_if: game-port handshake and RAM bus shared by the row arbiter and its peers.
interface board_row_if #(parameter int W = 160);
  logic         game_req, game_we, game_gnt, game_done, ram_we;
  logic [7:0]   game_addr, ram_addr;
  logic [W-1:0] game_wdata, game_rdata, ram_wdata, ram_rdata;
  modport slave (
    input  game_req, game_we, game_addr, game_wdata, ram_rdata,
    output game_gnt, game_done, game_rdata, ram_addr, ram_we, ram_wdata
  );
  modport master (
    output game_req, game_we, game_addr, game_wdata, ram_rdata,
    input  game_gnt, game_done, game_rdata, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/board_row_arbiter.sv
// board_row_arbiter: shares the single-port board row RAM between display row fetches (priority) and the game port.
module board_row_arbiter #(
  parameter int ROWS   = 20,
  parameter int COLS   = 10,
  parameter int CW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 LD_Row,
  input  logic [7:0]           rowNum,
  output logic [COLS-1:0][CW-1:0] Row,
  output logic                 rowReady,
  output logic                 disp_overrun,
  board_row_if.slave           bus
);
  localparam logic [1:0] LAT   = 2'(RD_LAT);
  localparam logic [7:0] NROWS = 8'(ROWS);
  typedef enum logic [1:0] {IDLE, DISP_RD, GAME_RD, GAME_WR} state_t;
  state_t                   state_q;
  logic [1:0]               cnt_q;
  logic                     ld_q, oor_q;
  logic [7:0]               row_num_q, disp_addr_q, disp_addr_d, ram_addr_q;
  logic                     disp_pend_q, disp_pend_d, disp_overrun_q, disp_overrun_d;
  logic                     ram_we_q, game_gnt_q, game_done_q, row_ready_q;
  logic [COLS*CW-1:0]       ram_wdata_q, game_rdata_q;
  logic [COLS-1:0][CW-1:0]  row_q;
  logic                     new_req, take_disp, oor_disp, oor_game;
  assign new_req   = LD_Row && (!ld_q || rowNum != row_num_q);
  assign take_disp = state_q == IDLE && disp_pend_q;
  assign oor_disp  = disp_addr_q >= NROWS;
  assign oor_game  = bus.game_addr >= NROWS;
  // A request landing in the cycle the old one is taken is fresh, not an overrun.
  always_comb begin
    disp_pend_d    = new_req || (disp_pend_q && !take_disp);
    disp_overrun_d = disp_overrun_q || (new_req && disp_pend_q && !take_disp);
    disp_addr_d    = new_req ? rowNum : disp_addr_q;
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      ld_q           <= 1'b0;
      oor_q          <= 1'b0;
      row_num_q      <= '0;
      disp_addr_q    <= '0;
      disp_pend_q    <= 1'b0;
      disp_overrun_q <= 1'b0;
      ram_addr_q     <= '0;
      ram_we_q       <= 1'b0;
      ram_wdata_q    <= '0;
      game_gnt_q     <= 1'b0;
      game_done_q    <= 1'b0;
      game_rdata_q   <= '0;
      row_q          <= '0;
      row_ready_q    <= 1'b0;
    end else begin
      ld_q           <= LD_Row;
      row_num_q      <= rowNum;
      disp_addr_q    <= disp_addr_d;
      disp_pend_q    <= disp_pend_d;
      disp_overrun_q <= disp_overrun_d;
      ram_we_q       <= 1'b0;
      game_gnt_q     <= 1'b0;
      game_done_q    <= 1'b0;
      row_ready_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (take_disp) begin
            state_q <= DISP_RD;
            oor_q   <= oor_disp;
            if (!oor_disp) ram_addr_q <= disp_addr_q;
          end else if (bus.game_req) begin
            state_q    <= bus.game_we ? GAME_WR : GAME_RD;
            oor_q      <= oor_game;
            game_gnt_q <= 1'b1;
            if (!oor_game) begin
              ram_addr_q <= bus.game_addr;
              ram_we_q   <= bus.game_we;
              if (bus.game_we) ram_wdata_q <= bus.game_wdata;
            end
          end
        end
        GAME_WR: begin
          state_q     <= IDLE;
          game_done_q <= 1'b1;
        end
        default: begin
          if (cnt_q == LAT) begin
            state_q <= IDLE;
            if (state_q == DISP_RD) begin
              row_q       <= oor_q ? '0 : bus.ram_rdata;
              row_ready_q <= 1'b1;
            end else begin
              game_rdata_q <= oor_q ? '0 : bus.ram_rdata;
              game_done_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
      endcase
    end
  end
  assign Row            = row_q;
  assign rowReady       = row_ready_q;
  assign disp_overrun   = disp_overrun_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign bus.game_gnt   = game_gnt_q;
  assign bus.game_done  = game_done_q;
  assign bus.game_rdata = game_rdata_q;
endmodule

// File: tb/tb_board_row_arbiter.sv
// tb_board_row_arbiter: directed cycle-exact checks of the board row arbiter against a behavioural RAM.
module tb_board_row_arbiter;
  logic              Clk = 1'b0, Reset_n = 1'b0, LD_Row = 1'b0;
  logic [7:0]        rowNum = '0;
  logic [9:0][15:0]  Row;
  logic              rowReady, disp_overrun;
  int                vectors = 0, miscompares = 0, rr_cnt = 0, dn_cnt = 0, rr0, dn0;
  logic [159:0]      mem [256];
  logic [159:0]      wd, wd2;
  board_row_if bus ();
  board_row_arbiter dut (
    .Clk(Clk), .Reset_n(Reset_n), .LD_Row(LD_Row), .rowNum(rowNum),
    .Row(Row), .rowReady(rowReady), .disp_overrun(disp_overrun), .bus(bus)
  );
  function automatic logic [159:0] pat(input int r);
    return (r == 5) ? {10{16'h0F00}} : {10{16'(16'hC000 + r * 16'h0101)}};
  endfunction
  always #5 Clk = ~Clk;
  // One-cycle read latency RAM, reloaded with known contents while reset is held.
  always @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
    end else begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= mem[bus.ram_addr];
    end
  end
  always @(negedge Clk) begin
    if (rowReady) rr_cnt++;
    if (bus.game_done) dn_cnt++;
  end
  task automatic tick(input int n = 1);
    repeat (n) @(posedge Clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    bus.game_req = 1'b0; bus.game_we = 1'b0; bus.game_addr = '0; bus.game_wdata = '0;
    wd  = {20{8'hA5}};
    wd2 = {10{16'h1955}};
    tick(3);
    Reset_n = 1'b1;
    chk("rst_row", 160'(Row), '0);
    chk("rst_ready", 160'(rowReady), '0);
    chk("rst_ovr", 160'(disp_overrun), '0);
    chk("rst_gnt_done", 160'({bus.game_gnt, bus.game_done, bus.ram_we}), '0);
    chk("rst_ram_addr", 160'(bus.ram_addr), '0);
    tick(2);
    // single display fetch of row 5
    LD_Row = 1'b1; rowNum = 8'd5; rr0 = rr_cnt;
    tick(); LD_Row = 1'b0;
    tick(); chk("disp_issue_addr", 160'(bus.ram_addr), 160'(5));
    chk("disp_no_we", 160'(bus.ram_we), '0);
    tick(); chk("disp_ready_early", 160'(rowReady), '0);
    tick(); chk("disp_ready", 160'(rowReady), 160'(1));
    chk("disp_row5", 160'(Row), pat(5));
    tick(3); chk("disp_one_fetch", 160'(rr_cnt - rr0), 160'(1));
    // level-held LD_Row
    LD_Row = 1'b1; rowNum = 8'd0; rr0 = rr_cnt;
    tick(800); chk("level_one_fetch", 160'(rr_cnt - rr0), 160'(1));
    chk("level_row0", 160'(Row), pat(0));
    rowNum = 8'd1;
    tick(10); chk("level_row_change", 160'(rr_cnt - rr0), 160'(2));
    chk("level_row1", 160'(Row), pat(1));
    LD_Row = 1'b0;
    tick(2);
    // collision: game write row 3 vs display edge row 7
    LD_Row = 1'b1; rowNum = 8'd7;
    bus.game_req = 1'b1; bus.game_we = 1'b1; bus.game_addr = 8'd3; bus.game_wdata = wd;
    tick(); chk("col_we", 160'(bus.ram_we), 160'(1));
    chk("col_gnt", 160'(bus.game_gnt), 160'(1));
    chk("col_addr", 160'(bus.ram_addr), 160'(3));
    chk("col_wdata", bus.ram_wdata, wd);
    bus.game_req = 1'b0;
    tick(); chk("col_done", 160'(bus.game_done), 160'(1));
    chk("col_we_off", 160'(bus.ram_we), '0);
    chk("col_idle_addr", 160'(bus.ram_addr), 160'(3));
    tick(); chk("col_disp_addr", 160'(bus.ram_addr), 160'(7));
    LD_Row = 1'b0;
    tick(2); chk("col_ready", 160'(rowReady), 160'(1));
    chk("col_row7", 160'(Row), pat(7));
    chk("col_mem3", mem[3], wd);
    tick(2);
    // overrun: two display edges during a game read of row 10
    bus.game_req = 1'b1; bus.game_we = 1'b0; bus.game_addr = 8'd10;
    tick(); chk("ovr_gnt", 160'(bus.game_gnt), 160'(1));
    bus.game_req = 1'b0; LD_Row = 1'b1; rowNum = 8'd2; rr0 = rr_cnt;
    tick(); chk("ovr_flag_early", 160'(disp_overrun), '0);
    rowNum = 8'd4;
    tick(); chk("ovr_game_done", 160'(bus.game_done), 160'(1));
    chk("ovr_game_rdata", bus.game_rdata, pat(10));
    chk("ovr_flag", 160'(disp_overrun), 160'(1));
    LD_Row = 1'b0;
    tick(); chk("ovr_addr4", 160'(bus.ram_addr), 160'(4));
    tick(2); chk("ovr_ready", 160'(rowReady), 160'(1));
    chk("ovr_row4", 160'(Row), pat(4));
    tick(2); chk("ovr_one_fetch", 160'(rr_cnt - rr0), 160'(1));
    // out-of-range display fetch
    LD_Row = 1'b1; rowNum = 8'd25;
    tick(); LD_Row = 1'b0;
    tick(); chk("oor_disp_addr", 160'(bus.ram_addr), 160'(4));
    chk("oor_disp_we", 160'(bus.ram_we), '0);
    tick(); chk("oor_disp_early", 160'(rowReady), '0);
    tick(); chk("oor_disp_ready", 160'(rowReady), 160'(1));
    chk("oor_disp_row", 160'(Row), '0);
    tick(2);
    // out-of-range game write then read
    bus.game_req = 1'b1; bus.game_we = 1'b1; bus.game_addr = 8'd200; bus.game_wdata = '1;
    tick(); chk("oor_wr_gnt", 160'(bus.game_gnt), 160'(1));
    chk("oor_wr_we", 160'(bus.ram_we), '0);
    bus.game_req = 1'b0;
    tick(); chk("oor_wr_done", 160'(bus.game_done), 160'(1));
    bus.game_req = 1'b1; bus.game_we = 1'b0; bus.game_addr = 8'd30;
    tick(); chk("oor_rd_gnt", 160'(bus.game_gnt), 160'(1));
    bus.game_req = 1'b0;
    tick(); chk("oor_rd_early", 160'(bus.game_done), '0);
    tick(); chk("oor_rd_done", 160'(bus.game_done), 160'(1));
    chk("oor_rd_data", bus.game_rdata, '0);
    tick(2);
    // read-after-write on row 19
    bus.game_req = 1'b1; bus.game_we = 1'b1; bus.game_addr = 8'd19; bus.game_wdata = wd2;
    tick(); chk("raw_wr_gnt", 160'(bus.game_gnt), 160'(1));
    bus.game_req = 1'b0;
    tick(); chk("raw_wr_done", 160'(bus.game_done), 160'(1));
    bus.game_req = 1'b1; bus.game_we = 1'b0;
    tick(); chk("raw_rd_gnt", 160'(bus.game_gnt), 160'(1));
    chk("raw_rd_addr", 160'(bus.ram_addr), 160'(19));
    bus.game_req = 1'b0;
    tick(); chk("raw_rd_early", 160'(bus.game_done), '0);
    tick(); chk("raw_rd_done", 160'(bus.game_done), 160'(1));
    chk("raw_rd_data", bus.game_rdata, wd2);
    tick(2);
    // asynchronous reset in the middle of a game read
    bus.game_req = 1'b1; bus.game_we = 1'b0; bus.game_addr = 8'd5;
    tick(); chk("mid_gnt", 160'(bus.game_gnt), 160'(1));
    bus.game_req = 1'b0;
    #2 Reset_n = 1'b0;
    #1 chk("mid_rst_gnt", 160'(bus.game_gnt), '0);
    chk("mid_rst_row", 160'(Row), '0);
    chk("mid_rst_rdata", bus.game_rdata, '0);
    chk("mid_rst_addr", 160'(bus.ram_addr), '0);
    chk("mid_rst_ovr", 160'(disp_overrun), '0);
    chk("mid_rst_ready", 160'(rowReady), '0);
    dn0 = dn_cnt;
    tick(2); Reset_n = 1'b1;
    tick(6); chk("mid_rst_no_done", 160'(dn_cnt - dn0), '0);
    chk("mid_rst_row_after", 160'(Row), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/board_row_arbiter.md
# board_row_arbiter

Sole owner of the single-port board row RAM (one 160-bit word per board row, 10 cells × 16-bit colour). It shares that RAM between the video path (`color_mapper` row fetches via `LD_Row`/`rowNum`) and the game-logic port (row read/write with req/gnt/done handshake). Display fetches have priority. Each fetched row is delivered as the `Row[10]` array that `color_mapper` consumes.

## Interface
- `ROWS`, 20: board rows; valid addresses 0..ROWS-1
- `COLS`, 10: cells per row
- `CW`, 16: bits per cell
- `RD_LAT`, 1: RAM read latency in cycles (1..3), counted from the issue cycle to the cycle `ram_rdata` is valid

- `Clk` in 1: system clock
- `Reset_n` in 1: asynchronous, active-low reset
- `LD_Row` in 1: display fetch request (level; may stay high many cycles)
- `rowNum` in 8: display row address
- `Row` out CW × COLS: display row register; `Row[i]` = word bits [CW·i+CW-1 : CW·i]
- `rowReady` out 1: one-cycle pulse when `Row` has been updated
- `disp_overrun` out 1: sticky flag; a pending display fetch was replaced before it was issued
- `game_req` in 1: game request; `game_we`/`game_addr`/`game_wdata` must be held stable while it is high
- `game_we` in 1: 1 = write, 0 = read
- `game_addr` in 8: game row address
- `game_wdata` in CW·COLS: game write data
- `game_gnt` out 1: one-cycle pulse in the RAM issue cycle
- `game_done` out 1: one-cycle pulse when the operation is complete
- `game_rdata` out CW·COLS: read result, held until the next game read completes
- `ram_addr` out 8: registered RAM address
- `ram_we` out 1: registered RAM write enable
- `ram_wdata` out CW·COLS: registered RAM write data
- `ram_rdata` in CW·COLS: RAM read data

## Operation
- **Display request detect.** A new display request is generated in cycle t when `LD_Row`=1 and either `LD_Row` was 0 in t-1 or `rowNum` differs from its value in t-1.
  - The request loads `disp_pend`=1 and `disp_addr`=`rowNum`; both are visible from t+1.
- **Overrun.** If a new request arrives while `disp_pend`=1 and the previous request has not yet been issued:
  - the address is overwritten;
  - `disp_overrun` is set.
  - A request arriving while a display read is in service becomes a fresh pending request and is not an overrun.
- **FSM states:** IDLE, DISP_RD, GAME_RD, GAME_WR.
  - IDLE: if `disp_pend`, go to DISP_RD and register `ram_addr`=`disp_addr`. Otherwise, if `game_req`, go to GAME_WR when `game_we`=1, else GAME_RD, and register `ram_addr`=`game_addr` (plus `ram_we`/`ram_wdata` for a write).
  - DISP_RD / GAME_RD: stay RD_LAT+1 cycles (issue cycle plus wait). Capture `ram_rdata` in the cycle it is valid, then go to IDLE.
  - GAME_WR: one cycle, then IDLE.
- **Issue-cycle side effects.** `disp_pend` clears in the DISP_RD issue cycle. `game_gnt` pulses in the GAME_RD/GAME_WR issue cycle.
- **Priority.** Display has strict priority over game.
  - A game request and a display edge in the same IDLE cycle: game wins, because pend is not yet visible.
  - At least one IDLE cycle separates any two operations.
- **Out-of-range address (≥ ROWS).**
  - No RAM access; `ram_we` stays 0 and `ram_addr` holds its old value.
  - Display: `Row` is loaded with all zeros, and `rowReady` pulses with the same latency as a real read.
  - Game read: `game_rdata` = 0, and `gnt`/`done` follow normal read timing.
  - Game write: dropped; `gnt`/`done` follow normal write timing.
- **Reset (async, any state).**
  - State returns to IDLE.
  - `disp_pend`, `disp_overrun`, `rowReady`, `game_gnt`, `game_done`, `ram_we` = 0.
  - `ram_addr` = 0, `ram_wdata` = 0, `Row` = all zero, `game_rdata` = 0.
  - An in-flight operation is abandoned, and no `done`/`rowReady` is produced for it.

## Timing
- Display, idle arbiter, edge in cycle 0:
  - cycle 1: pend=1, IDLE selects;
  - cycle 2: issue (`ram_addr` valid);
  - cycle 2+RD_LAT: `ram_rdata` is captured;
  - cycle 3+RD_LAT: new `Row` is visible and `rowReady`=1.
  - For RD_LAT=1, `rowReady` is in cycle 4.
- Game read, `game_req` high in IDLE cycle 0:
  - `game_gnt` in cycle 1;
  - `game_done` and valid `game_rdata` in cycle 2+RD_LAT.
- Game write, `game_req` high in IDLE cycle 0:
  - cycle 1: `ram_we`=1 for exactly one cycle and `game_gnt`=1;
  - cycle 2: `game_done`=1.
- Requester deassertion rules:
  - The game requester must drop `game_req` in the cycle after `game_gnt`. If `game_req` is still high in the next IDLE cycle, it is treated as a new request.
  - `ram_we` is never 1 outside the GAME_WR issue cycle.

## Test plan
- **Reset values:** assert `Reset_n`=0 mid-GAME_RD -> all outputs at their reset values immediately. After release, no `game_done`, and `Row` = 0.
- **Single display fetch:** RAM row 5 = {16'h0F00 × 10}; pulse `LD_Row` with `rowNum`=5, RD_LAT=1 -> `rowReady` 4 cycles after the edge, every `Row[i]`=16'h0F00, exactly one RAM read.
- **Level-held `LD_Row`:** hold `LD_Row` high for 800 cycles with `rowNum`=0 -> exactly one fetch. Then change `rowNum` to 1 while still high -> exactly one additional fetch of row 1.
- **Collision:** game write to row 3 (data 160'hA5…) raised in the same cycle as a display edge for row 7 -> write issues first (`ram_we` one cycle, `done` one cycle later). The display read of row 7 issues after one IDLE cycle.
- **Overrun and out-of-range:** two display edges (rows 2, 4) while a game read is in service -> only row 4 is fetched and `disp_overrun`=1. A display fetch of row 25 -> `Row` all zero, `rowReady` pulses, no RAM access.
- **Read-after-write:** game write of row 19 followed by a game read of row 19 -> `game_rdata` equals the written data, and `done` arrives 2+RD_LAT cycles after the read request.
